// File: rtl/waterbear_pkg.sv
// Shared types and constants for the waterbear program loader.
// Holds the loader FSM encoding, the error codes and the reserved-opcode mask.
package waterbear_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    localparam logic [1:0]  ERR_NONE = 2'b00;
    localparam logic [1:0]  ERR_ZERO = 2'b01;
    localparam logic [1:0]  ERR_CSUM = 2'b10;
    localparam logic [1:0]  ERR_RSV  = 2'b11;

    localparam logic [15:0] RSV_MASK = 16'hF800;

    // States in which a frame byte may be consumed.
    function automatic logic takes_byte(input state_e st);
        case (st)
            ST_COUNT, ST_HI, ST_LO, ST_CSUM: takes_byte = 1'b1;
            default:                         takes_byte = 1'b0;
        endcase
    endfunction

    function automatic logic rsv_hit(input logic [15:0] word);
        return (word & RSV_MASK) != 16'h0000;
    endfunction

endpackage

// File: rtl/loader_csum.sv
// Eight-bit running byte sum for the loader frame.
// zero reports whether the sum would be 0 once the presented byte is added.
module loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] data,
    output logic       zero
);

    logic [7:0] sum_r;
    logic [7:0] sum_next_s;

    assign sum_next_s = sum_r + data;
    assign zero       = (sum_next_s == 8'h00);

    // Accumulate accepted bytes; cleared at the start of each load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= 8'h00;
        end else if (clear) begin
            sum_r <= 8'h00;
        end else if (add_en) begin
            sum_r <= sum_next_s;
        end else begin
            sum_r <= sum_r;
        end
    end

endmodule

// File: rtl/waterbear_loader.sv
// Byte-stream program loader: receives a counted, checksummed frame of 16-bit
// words, writes them to program RAM and releases the CPU only on a clean load.
module waterbear_loader
    import waterbear_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

    state_e              state_r;
    state_e              state_n_s;
    logic [1:0]          err_code_n_s;
    logic                clr_s;
    logic                accept_s;
    logic                sum_zero_s;
    logic [15:0]         word_s;

    logic                in_ready_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [15:0]         mem_wdata_r;
    logic                cpu_rst_r;
    logic                done_r;
    logic                err_r;
    logic [1:0]          err_code_r;

    logic [7:0]          count_r;
    logic [7:0]          word_cnt_r;
    logic [7:0]          hi_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                rsv_r;

    assign accept_s = in_valid & in_ready_r;
    assign word_s   = {hi_r, in_data};

    loader_csum u_csum (
        .clk    (clk),
        .rst    (rst),
        .clear  (clr_s),
        .add_en (accept_s),
        .data   (in_data),
        .zero   (sum_zero_s)
    );

    // Next-state and error-code selection.
    always_comb begin
        state_n_s    = state_r;
        err_code_n_s = err_code_r;
        clr_s        = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_n_s    = ST_COUNT;
                    err_code_n_s = ERR_NONE;
                    clr_s        = 1'b1;
                end else begin
                    state_n_s = state_r;
                end
            end
            ST_COUNT: begin
                if (accept_s) begin
                    if (in_data == 8'h00) begin
                        state_n_s    = ST_ERR;
                        err_code_n_s = ERR_ZERO;
                    end else begin
                        state_n_s = ST_HI;
                    end
                end else begin
                    state_n_s = ST_COUNT;
                end
            end
            ST_HI: begin
                if (accept_s) begin
                    state_n_s = ST_LO;
                end else begin
                    state_n_s = ST_HI;
                end
            end
            ST_LO: begin
                if (accept_s) begin
                    if (word_cnt_r == (count_r - 8'd1)) begin
                        state_n_s = ST_CSUM;
                    end else begin
                        state_n_s = ST_HI;
                    end
                end else begin
                    state_n_s = ST_LO;
                end
            end
            ST_CSUM: begin
                // A bad checksum outranks a reserved-bit violation.
                if (accept_s) begin
                    if (!sum_zero_s) begin
                        state_n_s    = ST_ERR;
                        err_code_n_s = ERR_CSUM;
                    end else if (rsv_r) begin
                        state_n_s    = ST_ERR;
                        err_code_n_s = ERR_RSV;
                    end else begin
                        state_n_s = ST_DONE;
                    end
                end else begin
                    state_n_s = ST_CSUM;
                end
            end
            default: begin
                state_n_s    = ST_IDLE;
                err_code_n_s = ERR_NONE;
            end
        endcase
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= BASE_A;
            mem_wdata_r <= 16'h0000;
            cpu_rst_r   <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= ERR_NONE;
            count_r     <= 8'h00;
            word_cnt_r  <= 8'h00;
            hi_r        <= 8'h00;
            addr_r      <= BASE_A;
            rsv_r       <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            in_ready_r <= takes_byte(state_n_s);
            done_r     <= (state_n_s == ST_DONE);
            err_r      <= (state_n_s == ST_ERR);
            cpu_rst_r  <= (state_n_s != ST_DONE);
            err_code_r <= err_code_n_s;
            mem_we_r   <= 1'b0;
            if (clr_s) begin
                count_r    <= 8'h00;
                word_cnt_r <= 8'h00;
                addr_r     <= BASE_A;
                rsv_r      <= 1'b0;
            end else if (accept_s) begin
                case (state_r)
                    ST_COUNT: count_r <= in_data;
                    ST_HI:    hi_r    <= in_data;
                    ST_LO: begin
                        mem_we_r    <= 1'b1;
                        mem_wdata_r <= word_s;
                        mem_addr_r  <= addr_r;
                        addr_r      <= addr_r + ONE_A;
                        word_cnt_r  <= word_cnt_r + 8'd1;
                        rsv_r       <= rsv_r | rsv_hit(word_s);
                    end
                    default: begin
                        hi_r <= hi_r;
                    end
                endcase
            end else begin
                hi_r <= hi_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_rst   = cpu_rst_r;
    assign done      = done_r;
    assign err       = err_r;
    assign err_code  = err_code_r;

endmodule

// File: tb/tb_waterbear_loader.sv
// Scoreboard bench for waterbear_loader: two instances (base 0 and base 254)
// share one random frame stream; a reference model predicts writes and outcome.
module tb_waterbear_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        r0_in_ready, r0_mem_we, r0_cpu_rst, r0_done, r0_err;
    logic [7:0]  r0_mem_addr;
    logic [15:0] r0_mem_wdata;
    logic [1:0]  r0_err_code;
    logic        r1_in_ready, r1_mem_we, r1_cpu_rst, r1_done, r1_err;
    logic [7:0]  r1_mem_addr;
    logic [15:0] r1_mem_wdata;
    logic [1:0]  r1_err_code;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_w0[$];
    logic [23:0] exp_w1[$];
    logic [4:0]  exp_r0[$];
    logic [4:0]  exp_r1[$];
    logic [15:0] fw[$];
    logic        fin_prev0 = 1'b0;
    logic        fin_prev1 = 1'b0;

    always #5 clk = ~clk;

    waterbear_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r0_in_ready), .mem_we(r0_mem_we), .mem_addr(r0_mem_addr),
        .mem_wdata(r0_mem_wdata), .cpu_rst(r0_cpu_rst), .done(r0_done),
        .err(r0_err), .err_code(r0_err_code)
    );

    waterbear_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r1_in_ready), .mem_we(r1_mem_we), .mem_addr(r1_mem_addr),
        .mem_wdata(r1_mem_wdata), .cpu_rst(r1_cpu_rst), .done(r1_done),
        .err(r1_err), .err_code(r1_err_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_dut(input int id, input logic we, input logic [7:0] addr,
                           input logic [15:0] wd, input logic dn, input logic er,
                           input logic [1:0] code, input logic crst);
        logic [23:0] ew;
        logic [4:0]  exr;
        logic        fin;
        logic        prev;
        int          wsz;
        int          rsz;
        wsz = (id == 0) ? exp_w0.size() : exp_w1.size();
        rsz = (id == 0) ? exp_r0.size() : exp_r1.size();
        if (we === 1'b1) begin
            if (wsz == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut%0d_write: got %h@%h, expected no write", id, wd, addr);
            end else begin
                if (id == 0) ew = exp_w0.pop_front();
                else         ew = exp_w1.pop_front();
                check($sformatf("dut%0d_write", id), {8'h00, addr, wd}, {8'h00, ew});
            end
        end
        fin  = dn | er;
        prev = (id == 0) ? fin_prev0 : fin_prev1;
        if (fin === 1'b1 && prev !== 1'b1) begin
            if (rsz == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut%0d_result: got done=%b err=%b, expected no completion", id, dn, er);
            end else begin
                if (id == 0) exr = exp_r0.pop_front();
                else         exr = exp_r1.pop_front();
                check($sformatf("dut%0d_result{done,err,code,cpu_rst}", id),
                      {27'h0, dn, er, code, crst}, {27'h0, exr});
            end
        end
        if (id == 0) fin_prev0 = fin;
        else         fin_prev1 = fin;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            mon_dut(0, r0_mem_we, r0_mem_addr, r0_mem_wdata, r0_done, r0_err, r0_err_code, r0_cpu_rst);
            mon_dut(1, r1_mem_we, r1_mem_addr, r1_mem_wdata, r1_done, r1_err, r1_err_code, r1_cpu_rst);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset();
        check("rst_in_ready0", {31'h0, r0_in_ready}, 32'h0);
        check("rst_mem_we0", {31'h0, r0_mem_we}, 32'h0);
        check("rst_mem_addr0", {24'h0, r0_mem_addr}, 32'h0);
        check("rst_mem_addr1", {24'h0, r1_mem_addr}, 32'd254);
        check("rst_mem_wdata0", {16'h0, r0_mem_wdata}, 32'h0);
        check("rst_cpu_rst0", {31'h0, r0_cpu_rst}, 32'h1);
        check("rst_done0", {31'h0, r0_done}, 32'h0);
        check("rst_err0", {31'h0, r0_err}, 32'h0);
        check("rst_err_code0", {30'h0, r0_err_code}, 32'h0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_clears{done,err,code,cpu_rst,rdy}",
              {27'h0, r0_done, r0_err, r0_err_code, r0_cpu_rst, r0_in_ready}, 32'h3);
    endtask

    // Present one byte with occasional idle bubbles; returns after it is taken.
    task automatic send_byte(input logic [7:0] b, input logic poke_start);
        int w;
        w = 0;
        while ($urandom_range(0, 3) == 0 && w < 3) begin
            in_valid = 1'b0;
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        in_data  = b;
        start    = poke_start;
        w = 0;
        while (r0_in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (r0_in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=%b, expected 1", r0_in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Reference model: predicts writes/outcome from frame rules, then drives the frame.
    task automatic run_frame(input logic [7:0] n, input logic [7:0] cdelta);
        logic [7:0] s;
        logic [7:0] c;
        logic       any_rsv;
        int         w;
        s = n;
        any_rsv = 1'b0;
        for (int k = 0; k < int'(n); k++) begin
            s = s + fw[k][15:8] + fw[k][7:0];
            if ((fw[k] & 16'hF800) != 16'h0000) any_rsv = 1'b1;
            exp_w0.push_back({8'(k), fw[k]});
            exp_w1.push_back({8'(254 + k), fw[k]});
        end
        c = (8'h00 - s) + cdelta;
        if (n == 8'h00) begin
            exp_r0.push_back(5'b0_1_01_1);
        end else if (cdelta != 8'h00) begin
            exp_r0.push_back(5'b0_1_10_1);
        end else if (any_rsv) begin
            exp_r0.push_back(5'b0_1_11_1);
        end else begin
            exp_r0.push_back(5'b1_0_00_0);
        end
        exp_r1.push_back(exp_r0[exp_r0.size() - 1]);
        do_start();
        send_byte(n, 1'b0);
        if (n != 8'h00) begin
            for (int k = 0; k < int'(n); k++) begin
                send_byte(fw[k][15:8], 1'($urandom_range(0, 1)));
                send_byte(fw[k][7:0], 1'b0);
            end
            send_byte(c, 1'b0);
        end
        w = 0;
        while ((r0_done | r0_err) !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        if ((r0_done | r0_err) !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL completion_timeout: got done=%b err=%b, expected one high", r0_done, r0_err);
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    initial begin : stimulus
        logic [7:0] n;
        logic [7:0] cd;
        logic [15:0] wv;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        @(negedge clk);

        fw = '{16'h00C5, 16'h010D};
        run_frame(8'd2, 8'h00);
        fw = '{};
        run_frame(8'd0, 8'h00);
        fw = '{16'h00C5, 16'h010D};
        run_frame(8'd2, 8'h01);
        fw = '{16'h0800};
        run_frame(8'd1, 8'h00);
        fw = '{16'h0123, 16'h0456, 16'h0789};
        run_frame(8'd3, 8'h00);

        // Reset on the very edge that would accept the LO byte.
        do_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h02;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_reset();
        @(negedge clk);
        check("no_write_after_rst", {31'h0, r0_mem_we}, 32'h0);

        fw = '{16'h00C5, 16'h010D};
        run_frame(8'd2, 8'h00);

        for (int f = 0; f < 16; f++) begin
            n = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
            fw = '{};
            for (int k = 0; k < int'(n); k++) begin
                wv = 16'($urandom) & 16'h07FF;
                if ($urandom_range(0, 5) == 0) wv = wv | (16'h0800 << $urandom_range(0, 4));
                fw.push_back(wv);
            end
            cd = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame(n, cd);
        end

        repeat (3) @(negedge clk);
        check("leftover_writes0", exp_w0.size(), 32'd0);
        check("leftover_writes1", exp_w1.size(), 32'd0);
        check("leftover_results0", exp_r0.size(), 32'd0);
        check("leftover_results1", exp_r1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/waterbear_loader.md
WATERBEAR_LOADER -- requirements
Module: waterbear_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the program RAM address.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first RAM address written.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state on rising edge), then rst input 1.
REQ-004 SHALL have port start, input, 1 bit: begin a load; sampled in IDLE, DONE and ERR only.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data holds a byte.
REQ-006 SHALL have port in_data, input, 8 bits: frame byte.
REQ-007 SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we, output, 1 bit: program RAM write strobe.
REQ-009 SHALL have port mem_addr, output, ADDR_W bits: RAM write address.
REQ-010 SHALL have port mem_wdata, output, 16 bits: instruction word.
REQ-011 SHALL have port cpu_rst, output, 1 bit: holds the CPU in reset while high.
REQ-012 SHALL have port done, output, 1 bit: load completed, program valid.
REQ-013 SHALL have port err, output, 1 bit: load failed.
REQ-014 SHALL have port err_code, output, 2 bits: 01 zero count, 10 checksum, 11 reserved bits nonzero.

Function
REQ-015 SHALL transfer a byte only on a cycle where in_valid and in_ready are both 1.
REQ-016 SHALL accept this frame: count byte N (1..255 words), then N words each sent high byte first, then a checksum byte C.
REQ-017 SHALL run the FSM IDLE -> COUNT on start; COUNT -> HI on a nonzero byte, or -> ERR (01) on zero; HI -> LO; LO -> HI while words remain, otherwise -> CSUM; CSUM -> DONE or ERR.
REQ-018 SHALL drive in_ready=1 only in COUNT, HI, LO and CSUM, allowing one byte per cycle with no bubbles.
REQ-019 SHALL pulse mem_we for exactly one cycle, on the cycle after the LO byte is accepted.
REQ-020 SHALL write word k (0-based) with mem_wdata={hi,lo} and mem_addr=(BASE_ADDR+k) mod 2^ADDR_W, wrapping silently.
REQ-021 SHALL keep an 8-bit running sum of all accepted bytes including C; the checksum is good when the sum mod 256 is 0, otherwise -> ERR (10).
REQ-022 SHALL record a sticky flag when any word has bits [15:11] nonzero, still write the word, and go to ERR (11) at CSUM, with the checksum error taking priority.
REQ-023 SHALL hold cpu_rst=1 in every state except DONE; cpu_rst SHALL fall on the first cycle done is 1.
REQ-024 SHALL hold done and err as mutually exclusive levels until the next start.
REQ-025 SHALL ignore start while in COUNT, HI, LO or CSUM.
REQ-026 SHALL, on start in DONE or ERR, clear done, err and err_code, raise cpu_rst the next cycle, and enter COUNT.
REQ-027 SHALL wait indefinitely while in_valid=0; there is no timeout.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, take priority over all inputs and set: state IDLE, in_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, cpu_rst 1, done 0, err 0, err_code 00, sum 0, word counter 0.
REQ-029 SHALL, when rst arrives mid-load, drop any pending write and not issue mem_we on the following cycle.

Structure
REQ-030 SHALL place the FSM state enum, the err_code constants and the reserved-bit mask 16'hF800 in the shared package waterbear_pkg.
REQ-031 SHALL implement the sum/compare as a single sub-module, loader_csum (clear, add-enable, byte in, zero flag out); all other logic SHALL be inline.

Verification
REQ-032 SHALL verify: start, bytes 02 00 C5 01 0D 2B (sum=00) -> writes 0x00C5@0 and 0x010D@1, done=1, cpu_rst=0.
REQ-033 SHALL verify: start, byte 00 -> err=1, err_code=01, no mem_we, cpu_rst=1.
REQ-034 SHALL verify: same frame as REQ-032 with C=2C -> both writes occur, err=1, err_code=10, cpu_rst=1.
REQ-035 SHALL verify: word 0x0800 with a correct checksum -> write occurs, err_code=11.
REQ-036 SHALL verify: BASE_ADDR=254, N=3 -> addresses 254, 255, 0.
REQ-037 SHALL verify: rst asserted between the HI and LO bytes -> no write, IDLE, outputs at reset values; a following valid load succeeds.
